result_collector: RTL and testbench
===================================

# result_collector

Downstream stage of the Othello endgame-solver pipeline. It captures every `solved` pulse (task id plus signed final score) from the pipeline and buffers results in a FIFO that a host-side reader drains over a valid/ready handshake. It also tracks issued-but-unsolved tasks and flags protocol errors and overflow drops.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 4..256.
- `CNT_W`, 16: width of the drop counter and the outstanding-task counter.
- `iCLOCK`  in  1  sole clock; all state updates on the rising edge.
- `iRESET`  in  1  reset; asynchronous, active-high.
- `iSolved`  in  1  pipeline solved strobe; may be high on consecutive cycles.
- `iTaskid`  in  16  task id, qualified by `iSolved`.
- `iRes`  in  8  signed score −64..64, qualified by `iSolved`.
- `iIssue`  in  1  one-cycle pulse per task handed to the pipeline.
- `iClear`  in  1  synchronous clear of sticky flags and counters; FIFO contents kept.
- `oValid`  out  1  head entry present.
- `iReady`  in  1  reader accepts head when `oValid & iReady`.
- `oTaskid`  out  16  head task id.
- `oRes`  out  8  head score, signed.
- `oLevel`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `oOverflow`  out  1  sticky: a solve was dropped.
- `oDropCount`  out  CNT_W  saturating count of dropped solves.
- `oOutstanding`  out  CNT_W  issued minus solved tasks.
- `oProtoErr`  out  1  sticky: solve seen with zero outstanding, or issue while `oOutstanding` is at max.
- `oIdle`  out  1  `oOutstanding == 0` and FIFO empty.

## Operation
- Push: `iSolved` high → write `{iTaskid, iRes}` at tail. Every solve is counted as a solve, including dropped ones.
- Pop: `oValid & iReady` → advance head. `oTaskid`/`oRes` are don't-care while `oValid` is low, but they hold the last value and do not glitch.
- Full, with no pop in the same cycle: the push is dropped. `oOverflow` ← 1. `oDropCount` increments, saturating at all-ones.
- Full, with a pop in the same cycle: the push is accepted and the level stays `DEPTH`.
- Empty, with a push: a pop in that same cycle is impossible because `oValid` is 0. The entry appears the next cycle.
- Outstanding counter, per cycle:
  - `iIssue` only: +1.
  - Solve only: −1.
  - Both: unchanged.
  - Solve at 0: stays 0 and sets `oProtoErr`.
  - Issue at max: holds and sets `oProtoErr`.
- `iClear`:
  - Zeroes `oOverflow`, `oDropCount`, `oProtoErr` and `oOutstanding`.
  - Any push or pop in the same cycle still executes on the FIFO.
  - Same-cycle issue/solve counter deltas are discarded: clear wins.
- Reset: all pointers, level, counters and flags go to 0. `oValid` 0, `oTaskid` 0, `oRes` 0, `oIdle` 1. Reset mid-traffic discards all FIFO contents.

## Timing
- `iSolved` sampled at edge k → `oValid` high after edge k when the FIFO was empty. Latency is 1 cycle.
- Throughput: one push and one pop per cycle, sustained.
- `oLevel` updates on the same edge as push/pop: +1, −1 or 0.
- Flags and counters update on the edge that samples the causing event.
- All outputs are registered or decoded directly from registers. There is no combinational path from `iReady` to `oValid`.

## Structure
- Shared package `othello_pkg` holds:
  - `TASKID_W = 16`
  - `SCORE_W = 8`
  - `SCORE_MIN = -64`, `SCORE_MAX = 64`
  - packed struct `result_t {taskid, res}`, also reused by the host interface.
- One sub-module, `result_fifo`:
  - Generic FWFT FIFO over `result_t`, DEPTH entries.
  - Ports: push/full, pop/empty, level.
  - The top level adds drop logic, counters and flags.

## Test plan
- Single task: `iIssue` once, then `iSolved` with taskid 0x0005, res −12, `iReady`=1.
  - `oValid` is high one cycle after the solve, with 0x0005 and −12.
  - `oOutstanding` goes 1→0, then `oIdle`=1.
- Burst of 8 solves on back-to-back cycles, ids 0..7, res = id·2, `iReady`=0.
  - `oLevel`=8.
  - Then `iReady`=1 drains ids 0..7 in order over 8 cycles.
- Overflow with `DEPTH`=16 and `iReady`=0: 18 solves.
  - `oLevel`=16, `oOverflow`=1, `oDropCount`=2.
  - The drained ids are the first 16.
- Full plus simultaneous pop/push: with the FIFO full, `iReady`=1 and a solve in the same cycle.
  - No drop and `oLevel` stays 16.
  - The new id comes out last.
- Protocol error: solve with `oOutstanding`=0 → `oProtoErr`=1, `oOutstanding`=0.
  - `iClear` → flags 0.
  - `iIssue` and solve in the same cycle leave `oOutstanding` unchanged.
- Asynchronous reset asserted mid-drain with 5 entries queued → all outputs take their reset values immediately, with `oIdle`=1.

Source files
------------

// File: rtl/othello_pkg.sv
// Shared types and widths for the Othello endgame-solver pipeline.
// result_t is the record carried from the solver to the host reader.
package othello_pkg;

    localparam int TASKID_W  = 16;
    localparam int SCORE_W   = 8;
    localparam int SCORE_MIN = -64;
    localparam int SCORE_MAX = 64;

    typedef struct packed {
        logic        [TASKID_W-1:0] taskid;
        logic signed [SCORE_W-1:0]  res;
    } result_t;

endpackage

// File: rtl/result_collector_if.sv
// Host-side read port of the result collector: valid/ready handshake over result_t.
interface result_collector_if;
    import othello_pkg::*;

    logic    valid;
    logic    ready;
    result_t head;

    modport master (output valid, output head, input ready);
    modport slave  (input valid, input head, output ready);

endinterface

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO of result_t with a registered head word,
// so the head holds its last value when the FIFO runs empty.
module result_fifo
    import othello_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    iCLOCK,
    input  logic                    iRESET,
    input  logic                    push,
    input  result_t                 push_data,
    output logic                    full,
    input  logic                    pop,
    output logic                    empty,
    output result_t                 head,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    result_t        mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;
    logic [AW:0]    count_nxt;
    logic [AW-1:0]  rd_nxt;
    logic           pop_ok;
    logic           push_ok;
    logic           push_is_head;

    assign empty   = (count == '0);
    assign full    = (count == FULL_LVL);
    assign level   = count;
    assign pop_ok  = pop & ~empty;
    // A full FIFO can still take a push when a pop frees a slot this cycle.
    assign push_ok = push & (~full | pop_ok);
    assign rd_nxt  = rd_ptr + AW'(pop_ok);

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // The pushed word becomes the head when it is the only entry left next cycle.
    assign push_is_head = push_ok & ((count == '0) | ((count == (AW+1)'(1)) & pop_ok));

    always_ff @(posedge iCLOCK) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (count_nxt != '0) begin
                head <= push_is_head ? push_data : mem[rd_nxt];
            end
        end
    end

endmodule

// File: rtl/result_collector.sv
// Collects solved results into a FIFO for the host, tracks outstanding tasks,
// and records protocol errors and overflow drops.
module result_collector
    import othello_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                        iCLOCK,
    input  logic                        iRESET,
    input  logic                        iSolved,
    input  logic        [TASKID_W-1:0]  iTaskid,
    input  logic signed [SCORE_W-1:0]   iRes,
    input  logic                        iIssue,
    input  logic                        iClear,
    result_collector_if.master          host,
    output logic [$clog2(DEPTH):0]      oLevel,
    output logic                        oOverflow,
    output logic        [CNT_W-1:0]     oDropCount,
    output logic        [CNT_W-1:0]     oOutstanding,
    output logic                        oProtoErr,
    output logic                        oIdle
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    result_t solve_data;
    logic    fifo_full;
    logic    fifo_empty;
    logic    pop;
    logic    drop;

    assign solve_data = '{taskid: iTaskid, res: iRes};
    assign host.valid = ~fifo_empty;
    assign pop        = ~fifo_empty & host.ready;
    assign drop       = iSolved & fifo_full & ~pop;
    assign oIdle      = (oOutstanding == '0) & fifo_empty;

    result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .iCLOCK    (iCLOCK),
        .iRESET    (iRESET),
        .push      (iSolved),
        .push_data (solve_data),
        .full      (fifo_full),
        .pop       (pop),
        .empty     (fifo_empty),
        .head      (host.head),
        .level     (oLevel)
    );

    // Clear wins over any same-cycle counter or flag update; the FIFO is unaffected.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            oOverflow    <= 1'b0;
            oDropCount   <= '0;
            oOutstanding <= '0;
            oProtoErr    <= 1'b0;
        end else if (iClear) begin
            oOverflow    <= 1'b0;
            oDropCount   <= '0;
            oOutstanding <= '0;
            oProtoErr    <= 1'b0;
        end else begin
            if (iIssue && !iSolved) begin
                if (oOutstanding == CNT_MAX) begin
                    oProtoErr <= 1'b1;
                end else begin
                    oOutstanding <= oOutstanding + 1'b1;
                end
            end else if (iSolved && !iIssue) begin
                if (oOutstanding == '0) begin
                    oProtoErr <= 1'b1;
                end else begin
                    oOutstanding <= oOutstanding - 1'b1;
                end
            end
            if (drop) begin
                oOverflow <= 1'b1;
                if (oDropCount != CNT_MAX) begin
                    oDropCount <= oDropCount + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: expected results are queued when a solve
// is driven and compared as the host handshake drains them.
module tb_result_collector;
    import othello_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic                clk     = 1'b0;
    logic                rst     = 1'b1;
    logic                solved  = 1'b0;
    logic                issue   = 1'b0;
    logic                clear   = 1'b0;
    logic        [15:0]  taskid  = '0;
    logic signed [7:0]   res     = '0;
    logic [$clog2(DEPTH):0] level;
    logic                ovf;
    logic                perr;
    logic                idle;
    logic [CNT_W-1:0]    dropc;
    logic [CNT_W-1:0]    outst;

    result_collector_if hif();

    always #5 clk = ~clk;

    result_collector #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .iCLOCK       (clk),
        .iRESET       (rst),
        .iSolved      (solved),
        .iTaskid      (taskid),
        .iRes         (res),
        .iIssue       (issue),
        .iClear       (clear),
        .host         (hif.master),
        .oLevel       (level),
        .oOverflow    (ovf),
        .oDropCount   (dropc),
        .oOutstanding (outst),
        .oProtoErr    (perr),
        .oIdle        (idle)
    );

    result_t q[$];
    int      m_out;
    int      m_drop;
    bit      m_ovf;
    bit      m_perr;
    int      n_chk  = 0;
    int      n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic check_state();
        chk("level",       32'(level), 32'(q.size()));
        chk("outstanding", 32'(outst), 32'(m_out));
        chk("proto_err",   32'(perr),  32'(m_perr));
        chk("overflow",    32'(ovf),   32'(m_ovf));
        chk("drop_count",  32'(dropc), 32'(m_drop));
        chk("idle",        32'(idle),  32'(m_out == 0 && q.size() == 0));
    endtask

    task automatic model_reset();
        q.delete();
        m_out  = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
        m_perr = 1'b0;
    endtask

    // One clock cycle: called just after a falling edge, returns after the next one.
    task automatic step(input bit sv, input logic [15:0] id, input logic signed [7:0] r,
                        input bit rdy, input bit iss = 1'b0, input bit clr = 1'b0);
        int      pre;
        bit      pop;
        bit      drop;
        result_t e;
        pre = q.size();
        chk("valid", 32'(hif.valid), 32'(pre != 0));
        solved    = sv;
        taskid    = id;
        res       = r;
        hif.ready = rdy;
        issue     = iss;
        clear     = clr;
        pop  = rdy && (pre != 0);
        drop = 1'b0;
        if (pop) begin
            e = q.pop_front();
            chk("head_taskid", 32'(hif.head.taskid), 32'(e.taskid));
            chk("head_res", {24'd0, hif.head.res}, {24'd0, e.res});
        end
        if (sv) begin
            if (pre < DEPTH || pop) q.push_back('{taskid: id, res: r});
            else drop = 1'b1;
        end
        if (clr) begin
            m_out = 0; m_drop = 0; m_ovf = 1'b0; m_perr = 1'b0;
        end else begin
            if (iss && !sv) begin
                if (m_out == MAXC) m_perr = 1'b1; else m_out++;
            end else if (sv && !iss) begin
                if (m_out == 0) m_perr = 1'b1; else m_out--;
            end
            if (drop) begin
                m_ovf = 1'b1;
                if (m_drop != MAXC) m_drop++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 8'sd0, 1'b1);
    endtask

    initial begin
        hif.ready = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_valid",  32'(hif.valid),       32'd0);
        chk("rst_taskid", 32'(hif.head.taskid), 32'd0);
        chk("rst_res",    {24'd0, hif.head.res}, 32'd0);
        check_state();
        rst = 1'b0;

        // Single task round trip
        step(1'b0, 16'h0, 8'sd0, 1'b0, 1'b1);
        step(1'b1, 16'h0005, -8'sd12, 1'b1);
        drain(1);

        // Burst of 8 back-to-back solves, then ordered drain
        for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 8'(i * 2), 1'b0);
        drain(8);

        // Overflow: 18 solves into a 16-deep FIFO
        step(1'b0, 16'h0, 8'sd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) step(1'b1, 16'(16'h100 + i), 8'(i - 9), 1'b0);
        // Full with simultaneous pop and push: no drop, new id comes out last
        step(1'b1, 16'h01FF, 8'sd64, 1'b1);
        drain(16);

        // Protocol errors and clear
        step(1'b0, 16'h0, 8'sd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h0AA, -8'sd64, 1'b1);
        step(1'b0, 16'h0, 8'sd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'h0, 8'sd0, 1'b0, 1'b1);
        step(1'b1, 16'h0BB, 8'sd3, 1'b0, 1'b1);
        step(1'b0, 16'h0, 8'sd0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 16'h0CC, 8'sd1, 1'b1, 1'b0, 1'b1);
        drain(2);

        // Outstanding counter holds at max; drop counter saturates
        for (int i = 0; i < MAXC + 2; i++) step(1'b0, 16'h0, 8'sd0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 8'sd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + MAXC + 3; i++) step(1'b1, 16'(16'h200 + i), 8'sd7, 1'b0);
        drain(DEPTH);

        // Asynchronous reset mid-drain with 5 entries queued
        step(1'b0, 16'h0, 8'sd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 16'(16'h300 + i), 8'(-i), 1'b0);
        drain(1);
        hif.ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid",  32'(hif.valid),       32'd0);
        chk("arst_taskid", 32'(hif.head.taskid), 32'd0);
        chk("arst_res",    {24'd0, hif.head.res}, 32'd0);
        model_reset();
        check_state();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 16'h0, 8'sd0, 1'b1);
        step(1'b1, 16'h0400, 8'sd5, 1'b1, 1'b1);
        drain(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
